gpio_irq_ctrl: RTL and testbench
================================

GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter EOI_TIMEOUT, default 255, SHALL set the SERVICE-state cycle limit before automatic return to IDLE (range 1..255; 8-bit counter).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
clk  in  1  system clock, rising edge
reset  in  1  async active-high reset
irq_int0  in  1  interrupt source 0 (from gpio_interface)
irq_int1  in  1  interrupt source 1
irq_pinchange  in  1  interrupt source 2
irq_en  in  3  per-source arbitration enable, bit i = source i
prio_rr  in  1  0 = fixed priority (0 > 1 > 2), 1 = round-robin
irq_ack  in  1  CPU acknowledge, single-cycle pulse
irq_eoi  in  1  CPU end-of-interrupt, single-cycle pulse
pend_clr  in  3  software clear of pending bits, single-cycle pulses
cpu_irq  out  1  interrupt request to CPU
irq_vector  out  2  granted source 0..2; 3 = none
irq_pending  out  3  pending register
in_service  out  1  handler active
spurious  out  1  one-cycle pulse on invalid ack
eoi_timeout  out  1  one-cycle pulse on SERVICE timeout

Function
REQ-004 Each source SHALL be sampled into a prev register every cycle; a rising edge means src=1 and prev=0.
REQ-005 A rising edge SHALL set pending[i] at that clock edge regardless of irq_en; irq_en gates arbitration only.
REQ-006 Latency SHALL be: source high at edge N sets pending at edge N, and cpu_irq asserts after edge N+1.
REQ-007 pending[i] SHALL clear on pend_clr[i] or on irq_ack while granted vector = i; a same-cycle new edge SHALL win over the clear.
REQ-008 FSM states SHALL be IDLE, REQ and SERVICE.
REQ-009 In IDLE, if (pending & irq_en) != 0, the winner SHALL be latched into irq_vector and the FSM SHALL go to REQ.
REQ-010 In REQ, cpu_irq SHALL be 1 and irq_vector SHALL stay stable.
REQ-011 In REQ, irq_ack SHALL clear the winner's pending bit, update the RR pointer, and move the FSM to SERVICE.
REQ-012 In REQ, if the winner's pending bit clears (pend_clr) or its irq_en drops before ack, the FSM SHALL withdraw to IDLE with cpu_irq=0 and irq_vector=3 on the next cycle.
REQ-013 In SERVICE, in_service SHALL be 1, irq_vector SHALL hold the serviced source, and irq_eoi SHALL return the FSM to IDLE with irq_vector=3.
REQ-014 The SERVICE counter SHALL clear on entry; on reaching EOI_TIMEOUT without eoi, the block SHALL pulse eoi_timeout and go to IDLE.
REQ-015 If irq_eoi and the timeout coincide, eoi SHALL win and eoi_timeout SHALL stay 0.
REQ-016 Fixed mode SHALL grant the lowest enabled pending index.
REQ-017 RR mode SHALL search from (last_granted+1) mod 3 with wrap-around; the pointer SHALL update only on ack.
REQ-018 irq_ack outside REQ SHALL pulse spurious for one cycle with no other effect; irq_eoi outside SERVICE SHALL be ignored.
REQ-019 No nesting: edges during SERVICE SHALL only set pending bits.
REQ-020 prio_rr and irq_en changes SHALL take effect at the next IDLE arbitration.

Reset
REQ-021 While reset=1: state=IDLE, cpu_irq=0, irq_vector=3, irq_pending=0, in_service=0, spurious=0, eoi_timeout=0, prev=0, counter=0, last_granted=2 (so source 0 is searched first).
REQ-022 A source already high at reset release SHALL count as a rising edge.
REQ-023 Reset asserted mid-REQ or mid-SERVICE SHALL abort immediately to reset values, with no spurious or timeout pulse.

Structure
REQ-024 Package gpio_irq_pkg SHALL hold the FSM state enum, source index constants (SRC_INT0=0, SRC_INT1=1, SRC_PCH=2) and VEC_NONE=3.
REQ-025 Sub-module gpio_irq_arb SHALL be combinational: inputs pending&irq_en, prio_rr, last_granted; outputs valid and winner index.

Verification
REQ-026 Pulse irq_int1 high for 1 cycle with irq_en=3'b111 -> pending=3'b010 next cycle, cpu_irq=1 and vector=1 after one more; ack -> pending=0, in_service=1; eoi -> IDLE, vector=3.
REQ-027 Raise all three sources in the same cycle with prio_rr=0 -> grants 0, 1, 2 across three ack/eoi rounds; with prio_rr=1 and all repeatedly pending -> grant order 0, 1, 2, 0.
REQ-028 In REQ with vector=2, pulse pend_clr=3'b100 -> cpu_irq=0 and vector=3 next cycle; ack a cycle later -> spurious=1 for one cycle.
REQ-029 With EOI_TIMEOUT=4, ack and withhold eoi -> eoi_timeout pulses exactly 4 cycles after SERVICE entry, then FSM is IDLE.
REQ-030 Assert reset during SERVICE with pending=3'b011 -> all outputs at reset values within the same cycle; after release, cpu_irq stays 0 until a new edge arrives.
REQ-031 irq_en=3'b000 with an int0 edge -> pending[0]=1 and cpu_irq stays 0; set irq_en[0]=1 -> cpu_irq asserts one cycle later.

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// Shared types and constants for the GPIO interrupt controller.
package gpio_irq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_t;

   localparam int unsigned NUM_SRC = 3;

   localparam logic [1:0] SRC_INT0 = 2'd0;
   localparam logic [1:0] SRC_INT1 = 2'd1;
   localparam logic [1:0] SRC_PCH  = 2'd2;
   localparam logic [1:0] VEC_NONE = 2'd3;

   // Next source index with wrap-around 2 -> 0.
   function automatic logic [1:0] next_src(input logic [1:0] s);
      return (s >= SRC_PCH) ? SRC_INT0 : s + 2'd1;
   endfunction

   // One-hot mask for a source index; VEC_NONE maps to an empty mask.
   function automatic logic [2:0] src_onehot(input logic [1:0] v);
      logic [2:0] oh;
      case (v)
         SRC_INT0: oh = 3'b001;
         SRC_INT1: oh = 3'b010;
         SRC_PCH:  oh = 3'b100;
         default:  oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/gpio_irq_arb.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin
// starting after the last granted source.
module gpio_irq_arb
   import gpio_irq_pkg::*;
(
   input  logic [2:0] req,
   input  logic       prio_rr,
   input  logic [1:0] last_granted,
   output logic       valid,
   output logic [1:0] winner
);

   logic [1:0] idx;

   // Walk the three sources from the start index, first requester wins.
   always_comb begin
      valid  = 1'b0;
      winner = VEC_NONE;
      idx    = prio_rr ? next_src(last_granted) : SRC_INT0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (!valid && ((req & src_onehot(idx)) != '0)) begin
            valid  = 1'b1;
            winner = idx;
         end
         idx = next_src(idx);
      end
   end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Three-source edge-triggered interrupt controller with IDLE/REQ/SERVICE
// handshake, per-source enable, fixed or round-robin arbitration and
// end-of-interrupt timeout.
module gpio_irq_ctrl
   import gpio_irq_pkg::*;
#(
   parameter int unsigned EOI_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       irq_int0,
   input  logic       irq_int1,
   input  logic       irq_pinchange,
   input  logic [2:0] irq_en,
   input  logic       prio_rr,
   input  logic       irq_ack,
   input  logic       irq_eoi,
   input  logic [2:0] pend_clr,
   output logic       cpu_irq,
   output logic [1:0] irq_vector,
   output logic [2:0] irq_pending,
   output logic       in_service,
   output logic       spurious,
   output logic       eoi_timeout
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(EOI_TIMEOUT - 1);

   irq_state_t state;
   logic [2:0] src;
   logic [2:0] prev_q;
   logic [2:0] pending_q;
   logic [2:0] rise;
   logic [2:0] ack_clr;
   logic [2:0] pend_next;
   logic [1:0] last_granted;
   logic [7:0] svc_cnt;
   logic       arb_valid;
   logic [1:0] arb_winner;

   assign src         = {irq_pinchange, irq_int1, irq_int0};
   assign irq_pending = pending_q;

   // Edge detect and pending update; a new edge beats any clear.
   always_comb begin
      rise      = src & ~prev_q;
      ack_clr   = (state == ST_REQ && irq_ack) ? src_onehot(irq_vector) : '0;
      pend_next = (pending_q & ~(pend_clr | ack_clr)) | rise;
   end

   // Source history and pending register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q    <= '0;
         pending_q <= '0;
      end else begin
         prev_q    <= src;
         pending_q <= pend_next;
      end
   end

   gpio_irq_arb u_arb (
      .req          (pending_q & irq_en),
      .prio_rr      (prio_rr),
      .last_granted (last_granted),
      .valid        (arb_valid),
      .winner       (arb_winner)
   );

   // Handshake FSM with registered outputs. Withdrawal in REQ looks at the
   // next pending value so a clear is honoured at the edge it is sampled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         cpu_irq      <= 1'b0;
         irq_vector   <= VEC_NONE;
         in_service   <= 1'b0;
         spurious     <= 1'b0;
         eoi_timeout  <= 1'b0;
         svc_cnt      <= '0;
         last_granted <= SRC_PCH;
      end else begin
         spurious    <= irq_ack && (state != ST_REQ);
         eoi_timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  state      <= ST_REQ;
                  cpu_irq    <= 1'b1;
                  irq_vector <= arb_winner;
               end
            end
            ST_REQ: begin
               if (irq_ack) begin
                  state        <= ST_SERVICE;
                  cpu_irq      <= 1'b0;
                  in_service   <= 1'b1;
                  svc_cnt      <= '0;
                  last_granted <= irq_vector;
               end else if ((pend_next & irq_en & src_onehot(irq_vector)) == '0) begin
                  state      <= ST_IDLE;
                  cpu_irq    <= 1'b0;
                  irq_vector <= VEC_NONE;
               end
            end
            ST_SERVICE: begin
               if (irq_eoi) begin
                  state      <= ST_IDLE;
                  in_service <= 1'b0;
                  irq_vector <= VEC_NONE;
               end else if (svc_cnt == TIMEOUT_LAST) begin
                  state       <= ST_IDLE;
                  in_service  <= 1'b0;
                  irq_vector  <= VEC_NONE;
                  eoi_timeout <= 1'b1;
               end else begin
                  svc_cnt <= svc_cnt + 8'd1;
               end
            end
            default: begin
               state      <= ST_IDLE;
               cpu_irq    <= 1'b0;
               in_service <= 1'b0;
               irq_vector <= VEC_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a model.
module tb_gpio_irq_ctrl;

   localparam int unsigned TO = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       irq_int0 = 1'b0;
   logic       irq_int1 = 1'b0;
   logic       irq_pinchange = 1'b0;
   logic [2:0] irq_en = '0;
   logic       prio_rr = 1'b0;
   logic       irq_ack = 1'b0;
   logic       irq_eoi = 1'b0;
   logic [2:0] pend_clr = '0;
   logic       cpu_irq;
   logic [1:0] irq_vector;
   logic [2:0] irq_pending;
   logic       in_service;
   logic       spurious;
   logic       eoi_timeout;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   gpio_irq_ctrl #(.EOI_TIMEOUT(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .irq_int0      (irq_int0),
      .irq_int1      (irq_int1),
      .irq_pinchange (irq_pinchange),
      .irq_en        (irq_en),
      .prio_rr       (prio_rr),
      .irq_ack       (irq_ack),
      .irq_eoi       (irq_eoi),
      .pend_clr      (pend_clr),
      .cpu_irq       (cpu_irq),
      .irq_vector    (irq_vector),
      .irq_pending   (irq_pending),
      .in_service    (in_service),
      .spurious      (spurious),
      .eoi_timeout   (eoi_timeout)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 = idle, 1 = request, 2 = servicing.
   logic [2:0] m_prev, m_pend;
   int         m_mode, m_vec, m_last, m_cnt;
   logic       m_spur, m_to;

   task automatic model_step();
      logic [2:0] s, np;
      int start, j;
      s = {irq_pinchange, irq_int1, irq_int0};
      m_spur = irq_ack && (m_mode != 1);
      m_to = 1'b0;
      for (int i = 0; i < 3; i++) begin
         np[i] = m_pend[i];
         if (pend_clr[i]) np[i] = 1'b0;
         if (m_mode == 1 && irq_ack && m_vec == i) np[i] = 1'b0;
         if (s[i] && !m_prev[i]) np[i] = 1'b1;
      end
      case (m_mode)
         0: begin
            start = prio_rr ? (m_last + 1) % 3 : 0;
            for (int k = 0; k < 3; k++) begin
               j = (start + k) % 3;
               if (m_mode == 0 && m_pend[j] && irq_en[j]) begin
                  m_mode = 1;
                  m_vec = j;
               end
            end
         end
         1: begin
            if (irq_ack) begin
               m_mode = 2;
               m_last = m_vec;
               m_cnt = 0;
            end else if (!(np[m_vec] && irq_en[m_vec])) begin
               m_mode = 0;
               m_vec = 3;
            end
         end
         default: begin
            if (irq_eoi) begin
               m_mode = 0;
               m_vec = 3;
            end else begin
               m_cnt++;
               if (m_cnt == TO) begin
                  m_to = 1'b1;
                  m_mode = 0;
                  m_vec = 3;
               end
            end
         end
      endcase
      m_prev = s;
      m_pend = np;
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_prev = '0; m_pend = '0; m_mode = 0; m_vec = 3; m_last = 2;
         m_cnt = 0; m_spur = 1'b0; m_to = 1'b0;
      end else begin
         model_step();
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("cpu_irq", {7'd0, cpu_irq}, {7'd0, m_mode == 1});
      chk("irq_vector", {6'd0, irq_vector}, (m_mode == 0) ? 8'd3 : 8'(m_vec));
      chk("irq_pending", {5'd0, irq_pending}, {5'd0, m_pend});
      chk("in_service", {7'd0, in_service}, {7'd0, m_mode == 2});
      chk("spurious", {7'd0, spurious}, {7'd0, m_spur});
      chk("eoi_timeout", {7'd0, eoi_timeout}, {7'd0, m_to});
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input logic [2:0] v);
      {irq_pinchange, irq_int1, irq_int0} = v;
   endtask

   int exp_rr [4] = '{0, 1, 2, 0};

   initial begin
      // Reset values
      cyc(); cyc();
      chk("lit_rst_cpu_irq", {7'd0, cpu_irq}, 8'd0);
      chk("lit_rst_vector", {6'd0, irq_vector}, 8'd3);
      chk("lit_rst_pending", {5'd0, irq_pending}, 8'd0);
      chk("lit_rst_in_service", {7'd0, in_service}, 8'd0);
      reset = 1'b0;
      irq_en = 3'b111;
      cyc();

      // Single int1 pulse through the full handshake
      irq_int1 = 1'b1; cyc(); irq_int1 = 1'b0;
      chk("lit_basic_pend", {5'd0, irq_pending}, 8'h02);
      chk("lit_basic_irq_early", {7'd0, cpu_irq}, 8'd0);
      cyc();
      chk("lit_basic_irq", {7'd0, cpu_irq}, 8'd1);
      chk("lit_basic_vec", {6'd0, irq_vector}, 8'd1);
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      chk("lit_basic_ack_pend", {5'd0, irq_pending}, 8'd0);
      chk("lit_basic_insvc", {7'd0, in_service}, 8'd1);
      irq_eoi = 1'b1; cyc(); irq_eoi = 1'b0;
      chk("lit_basic_eoi_vec", {6'd0, irq_vector}, 8'd3);
      chk("lit_basic_eoi_insvc", {7'd0, in_service}, 8'd0);

      // Fixed priority with all three pending
      set_src(3'b111); cyc(); set_src(3'b000);
      for (int r = 0; r < 3; r++) begin
         cyc();
         chk("lit_fixed_vec", {6'd0, irq_vector}, 8'(r));
         irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
         irq_eoi = 1'b1; cyc(); irq_eoi = 1'b0;
      end

      // Round-robin with all sources repeatedly pending
      prio_rr = 1'b1;
      for (int r = 0; r < 4; r++) begin
         set_src(3'b111); cyc(); set_src(3'b000);
         cyc();
         chk("lit_rr_vec", {6'd0, irq_vector}, 8'(exp_rr[r]));
         irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
         irq_eoi = 1'b1; cyc(); irq_eoi = 1'b0;
      end
      prio_rr = 1'b0;
      irq_en = 3'b000; pend_clr = 3'b111; cyc(); pend_clr = '0; cyc();

      // Withdrawal on pend_clr, then late ack is spurious
      irq_en = 3'b100;
      irq_pinchange = 1'b1; cyc(); irq_pinchange = 1'b0;
      cyc();
      chk("lit_wd_vec", {6'd0, irq_vector}, 8'd2);
      pend_clr = 3'b100; cyc(); pend_clr = '0;
      chk("lit_wd_irq", {7'd0, cpu_irq}, 8'd0);
      chk("lit_wd_vec_none", {6'd0, irq_vector}, 8'd3);
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      chk("lit_wd_spurious", {7'd0, spurious}, 8'd1);
      cyc();
      chk("lit_wd_spurious_end", {7'd0, spurious}, 8'd0);

      // EOI timeout after TO cycles in service
      irq_en = 3'b001;
      irq_int0 = 1'b1; cyc(); irq_int0 = 1'b0;
      cyc();
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      chk("lit_to_insvc", {7'd0, in_service}, 8'd1);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk("lit_to_pulse", {7'd0, eoi_timeout}, (k == 4) ? 8'd1 : 8'd0);
      end
      chk("lit_to_idle", {7'd0, in_service}, 8'd0);
      cyc();
      chk("lit_to_pulse_end", {7'd0, eoi_timeout}, 8'd0);

      // Reset in SERVICE with two pending bits
      irq_en = 3'b111;
      set_src(3'b011); cyc(); set_src(3'b000);
      cyc();
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      irq_int0 = 1'b1; cyc(); irq_int0 = 1'b0;
      chk("lit_rs_pend", {5'd0, irq_pending}, 8'h03);
      chk("lit_rs_insvc", {7'd0, in_service}, 8'd1);
      reset = 1'b1;
      #1;
      chk("lit_rs_now_pend", {5'd0, irq_pending}, 8'd0);
      chk("lit_rs_now_insvc", {7'd0, in_service}, 8'd0);
      chk("lit_rs_now_vec", {6'd0, irq_vector}, 8'd3);
      cyc(); cyc();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("lit_rs_quiet", {7'd0, cpu_irq}, 8'd0);
      end
      irq_pinchange = 1'b1; cyc(); irq_pinchange = 1'b0;
      cyc();
      chk("lit_rs_new_irq", {7'd0, cpu_irq}, 8'd1);
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      irq_eoi = 1'b1; cyc(); irq_eoi = 1'b0;

      // Source high across reset release counts as an edge
      irq_en = 3'b000;
      reset = 1'b1; irq_int0 = 1'b1; cyc();
      reset = 1'b0; cyc();
      chk("lit_rel_pend", {5'd0, irq_pending}, 8'h01);
      irq_int0 = 1'b0;
      pend_clr = 3'b111; cyc(); pend_clr = '0;

      // Disabled source stays pending until enabled
      irq_int0 = 1'b1; cyc(); irq_int0 = 1'b0;
      cyc(); cyc();
      chk("lit_en_pend", {5'd0, irq_pending}, 8'h01);
      chk("lit_en_quiet", {7'd0, cpu_irq}, 8'd0);
      irq_en = 3'b001; cyc();
      chk("lit_en_irq", {7'd0, cpu_irq}, 8'd1);
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      irq_eoi = 1'b1; cyc(); irq_eoi = 1'b0;

      // Randomized run
      irq_en = 3'b111;
      for (int n = 0; n < 4000; n++) begin
         set_src({($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0)});
         if ($urandom_range(0, 15) == 0) irq_en = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 63) == 0) prio_rr = ~prio_rr;
         irq_ack = ($urandom_range(0, 3) == 0);
         irq_eoi = ($urandom_range(0, 6) == 0);
         pend_clr = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 19) == 0)};
         reset = ($urandom_range(0, 299) == 0);
         cyc();
      end
      set_src(3'b000); irq_ack = 1'b0; irq_eoi = 1'b0; pend_clr = '0; reset = 1'b0;
      cyc(); cyc(); cyc();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
